aes_input_loader: RTL and testbench
===================================

AES_INPUT_LOADER -- requirements
Module: aes_input_loader

Interface
REQ-001 SHALL have parameter CORE_LATENCY, default 12, giving the cycles from a load pulse to the AES core's cipher_text being stable.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge triggered.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, indicating the upstream word is valid.
REQ-005 SHALL have port in_ready, output, 1, indicating the loader accepts the word.
REQ-006 SHALL have port in_data, input, 32, the word payload.
REQ-007 SHALL have port in_sel, input, 1, the word target: 0 = plaintext, 1 = key.
REQ-008 SHALL have port key, output, 128, the assembled key to the core.
REQ-009 SHALL have port plain_text, output, 128, the assembled plaintext to the core.
REQ-010 SHALL have port load_plain_text, output, 1, a one-cycle start pulse to the core.
REQ-011 SHALL have port cipher_text, input, 128, the core result.
REQ-012 SHALL have port res_valid, output, 1, indicating the result is held.
REQ-013 SHALL have port res_ready, input, 1, indicating downstream accepts the result.
REQ-014 SHALL have port res_data, output, 128, the captured ciphertext.
REQ-015 SHALL have port busy, output, 1, high in RUN and RESULT.

Function
REQ-016 SHALL implement states COLLECT, RUN and RESULT, with COLLECT entered on reset.
REQ-017 SHALL assert in_ready in COLLECT only when the buffer selected by in_sel holds fewer than 4 words, and SHALL hold in_ready low in RUN and RESULT.
REQ-018 SHALL load accepted words big-endian: the first word goes to bits [127:96] and the fourth to [31:0], with separate 3-bit counts for key and plaintext.
REQ-019 SHALL, when both counts equal 4 in COLLECT, assert load_plain_text for exactly one cycle, enter RUN, clear the plaintext count and load lat_cnt with CORE_LATENCY.
REQ-020 SHALL hold key and plain_text stable from the load pulse until the next accepted word of the same target.
REQ-021 SHALL decrement lat_cnt once per cycle in RUN, and SHALL capture cipher_text into res_data, set res_valid and enter RESULT on the edge where lat_cnt is 0.
REQ-022 SHALL make that capture edge the (CORE_LATENCY+1)-th rising edge after the edge that raised load_plain_text.
REQ-023 SHALL hold res_valid and res_data in RESULT until res_valid && res_ready, then clear res_valid and return to COLLECT on that edge.
REQ-024 SHALL ignore in_valid while in_ready is low; the upstream holds its word.
REQ-025 SHALL have no behaviour for res_ready high in COLLECT or RUN.
REQ-026 SHALL, when a key word arrives while the plaintext is full but the key is partial, launch only when the fourth key word lands.

Reset
REQ-027 SHALL, on rst, immediately clear: state to COLLECT, both counts, lat_cnt, key, plain_text, res_data to 0, and load_plain_text, res_valid, busy and in_ready to 0.
REQ-028 SHALL restart cleanly in COLLECT after a mid-RUN rst, with no res_valid pulse and the core result discarded; the core is reset separately.

Configuration
REQ-029 SHALL, with AES_KEY_REUSE_EN defined, keep the key count at 4 after launch, so subsequent blocks need only 4 plaintext words.
REQ-030 SHALL, without AES_KEY_REUSE_EN, clear the key count at launch, so every block needs 4 key and 4 plaintext words.

Structure
REQ-031 SHALL place the state enum, word width (32), word count (4) and the FIPS-197 test constants in shared package aes_pkg.
REQ-032 SHALL use one sub-module, aes_word_packer (a 4x32-bit shift-in register with a count), instantiated twice: once for key and once for plaintext.

Verification
REQ-033 SHALL cover: key words 00010203, 04050607, 08090a0b, 0c0d0e0f, then pt words 00112233, 44556677, 8899aabb, ccddeeff, with a core model -> one load pulse, then res_data = 69c4e0d86a7b0430d8cdb78070b4c55a exactly 13 edges later.
REQ-034 SHALL cover: res_ready held low for 20 cycles after res_valid -> res_data stable, in_ready low, no second load pulse.
REQ-035 SHALL cover: a fifth key word offered with the key full -> in_ready 0 for that word, and the key unchanged.
REQ-036 SHALL cover: rst asserted at lat_cnt = 5 -> all outputs 0 the same cycle, state COLLECT, and res_valid never set.
REQ-037 SHALL cover: two blocks back-to-back with the macro defined -> the second load follows 4 pt words only; without the macro -> no load until 4 new key words arrive.
REQ-038 SHALL cover: interleaved in_sel 1/0/1/0... words -> correct big-endian assembly in both buffers and a single launch.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES input loader: FSM states, word geometry
// and the FIPS-197 appendix C.1 reference vector.
package aes_pkg;

  localparam int WORD_W   = 32;
  localparam int WORD_CNT = 4;
  localparam int BLOCK_W  = WORD_W * WORD_CNT;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_RUN     = 2'd1,
    ST_RESULT  = 2'd2
  } state_t;

  localparam logic [BLOCK_W-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [BLOCK_W-1:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [BLOCK_W-1:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/aes_word_packer.sv
// 4x32-bit shift-in register with a word count; first word ends up in the top lane.
// Words offered while full are dropped; the count clears independently of the data.
module aes_word_packer
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               shift,
  input  logic               clr_cnt,
  input  logic [WORD_W-1:0]  word,
  output logic [BLOCK_W-1:0] data,
  output logic [CNT_W-1:0]   cnt
);

  logic take;

  assign take = shift && (cnt != CNT_W'(WORD_CNT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      cnt  <= '0;
    end else begin
      if (take) begin
        data <= {data[BLOCK_W-WORD_W-1:0], word};
      end
      if (clr_cnt) begin
        cnt <= '0;
      end else if (take) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_input_loader.sv
// Assembles 32-bit key/plaintext words for an AES core, pulses load, captures cipher_text.
// Result appears CORE_LATENCY+1 edges after the load pulse; in_ready drops while busy or target full.
// AES_KEY_REUSE_EN keeps the key loaded across blocks so later blocks need plaintext only.
module aes_input_loader
  import aes_pkg::*;
#(
  parameter int CORE_LATENCY = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_sel,
  output logic [127:0] key,
  output logic [127:0] plain_text,
  output logic         load_plain_text,
  input  logic [127:0] cipher_text,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         busy
);

  localparam int LAT_W = (CORE_LATENCY < 1) ? 1 : $clog2(CORE_LATENCY + 1);

  state_t             state, state_d;
  logic [LAT_W-1:0]   lat_cnt;
  logic [CNT_W-1:0]   key_cnt, pt_cnt;
  logic               key_full, pt_full;
  logic               accept, launch, capture, release_res, key_clr;

  assign key_full = (key_cnt == CNT_W'(WORD_CNT));
  assign pt_full  = (pt_cnt == CNT_W'(WORD_CNT));

  // Gated by rst so in_ready reads low for the whole reset window, not just after it.
  assign in_ready = !rst && (state == ST_COLLECT) && (in_sel ? !key_full : !pt_full);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != ST_COLLECT);

`ifdef AES_KEY_REUSE_EN
  assign key_clr = 1'b0;
`else
  assign key_clr = launch;
`endif

  aes_word_packer u_key_packer (
    .clk     (clk),
    .rst     (rst),
    .shift   (accept && in_sel),
    .clr_cnt (key_clr),
    .word    (in_data),
    .data    (key),
    .cnt     (key_cnt)
  );

  aes_word_packer u_pt_packer (
    .clk     (clk),
    .rst     (rst),
    .shift   (accept && !in_sel),
    .clr_cnt (launch),
    .word    (in_data),
    .data    (plain_text),
    .cnt     (pt_cnt)
  );

  always_comb begin
    state_d     = state;
    launch      = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state)
      ST_COLLECT: begin
        if (key_full && pt_full) begin
          launch  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (lat_cnt == '0) begin
          capture = 1'b1;
          state_d = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_valid && res_ready) begin
          release_res = 1'b1;
          state_d     = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // lat_cnt loads on the launch edge and reaches 0 after CORE_LATENCY RUN edges,
  // so the capture lands on edge CORE_LATENCY+1 after the pulse was raised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_COLLECT;
      lat_cnt         <= '0;
      load_plain_text <= 1'b0;
      res_valid       <= 1'b0;
      res_data        <= '0;
    end else begin
      state           <= state_d;
      load_plain_text <= launch;
      if (launch) begin
        lat_cnt <= LAT_W'(CORE_LATENCY);
      end else if ((state == ST_RUN) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (capture) begin
        res_data  <= cipher_text;
        res_valid <= 1'b1;
      end else if (release_res) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_input_loader.sv
// Scoreboard bench for aes_input_loader with a fixed-latency AES core model.
module tb_aes_input_loader;
  import aes_pkg::*;

  localparam int LAT = 12;

  localparam logic [127:0] P2 = 128'h11111111222222223333333344444444;
  localparam logic [127:0] K2 = 128'ha0a1a2a3b0b1b2b3c0c1c2c3d0d1d2d3;
  localparam logic [127:0] K5 = 128'h10000001200000023000000340000004;
  localparam logic [127:0] P5 = 128'h0a0b0c0d1a1b1c1d2a2b2c2d3a3b3c3d;
`ifndef AES_KEY_REUSE_EN
  localparam logic [127:0] K3 = 128'hdeadbeefcafef00d0123456789abcdef;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_sel = 1'b0;
  logic [127:0] key, plain_text, cipher_text, res_data;
  logic         load_plain_text, res_valid, busy;
  logic         res_ready = 1'b0;

  int n_vec = 0, n_err = 0, cyc = 0, n_load = 0, n_rv = 0, t_load = 0;
  logic [127:0] q_key[$], q_pt[$], q_res[$];

  aes_input_loader #(.CORE_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .key(key), .plain_text(plain_text), .load_plain_text(load_plain_text),
    .cipher_text(cipher_text), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return k ^ {p[63:0], p[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  // Core model: garbage until LAT edges after the pulse, then the result.
  int           core_cnt;
  logic [127:0] core_res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_cnt <= 0; core_res <= '0; cipher_text <= '0;
    end else if (load_plain_text) begin
      core_cnt    <= 1;
      core_res    <= core_f(key, plain_text);
      cipher_text <= 128'hbadbadbadbadbadbadbadbadbadbad00;
    end else if (core_cnt != 0) begin
      if (core_cnt == LAT - 1) begin
        cipher_text <= core_res;
        core_cnt    <= 0;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic plp = 1'b0, prv = 1'b0;
    forever begin
      @(negedge clk);
      if (load_plain_text) begin
        chk1("load_single_cycle", plp, 1'b0);
        if (!plp) begin
          n_load++;
          t_load = cyc;
          if (q_key.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_load: key %h pt %h", key, plain_text);
          end else begin
            chk("launch_key", key, q_key.pop_front());
            chk("launch_pt", plain_text, q_pt.pop_front());
          end
        end
      end
      if (res_valid && !prv) begin
        n_rv++;
        chki("result_latency_edges", cyc - t_load, LAT + 1);
        if (q_res.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_result: res_data %h", res_data);
        end else begin
          chk("res_data", res_data, q_res.pop_front());
        end
      end
      plp = load_plain_text;
      prv = res_valid;
    end
  endtask

  task automatic send(input logic sel, input logic [31:0] d);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_sel = sel; in_data = d; in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL send_accept: in_ready stayed 0, required 1 (sel %0d word %h)", sel, d);
    end
  endtask

  task automatic send_block(input logic sel, input logic [127:0] blk);
    for (int i = 0; i < 4; i++) send(sel, blk[127-32*i -: 32]);
  endtask

  task automatic wait_res(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: res_valid 0 after 100 cycles, required 1", name);
    end
  endtask

  task automatic drain();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk1("res_valid_cleared", res_valid, 1'b0);
    chk1("busy_after_drain", busy, 1'b0);
  endtask

  task automatic offer_reject(input logic [31:0] d, input logic [127:0] exp_key);
    @(negedge clk);
    in_sel = 1'b1; in_data = d; in_valid = 1'b1;
    @(negedge clk);
    chk1("fifth_key_in_ready", in_ready, 1'b0);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("key_unchanged", key, exp_key);
  endtask

  initial begin
    int n0;
    fork monitor(); join_none

    // Reset state
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_load", load_plain_text, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_key", key, '0);
    chk("rst_pt", plain_text, '0);
    chk("rst_res_data", res_data, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("in_ready_after_reset", in_ready, 1'b1);

    // FIPS-197 block, then result held with res_ready low
    q_key.push_back(FIPS_KEY); q_pt.push_back(FIPS_PT); q_res.push_back(FIPS_CT);
    send_block(1'b1, FIPS_KEY);
    send_block(1'b0, FIPS_PT);
    wait_res("fips");
    n0 = n_load;
    in_sel = 1'b0; in_data = 32'hffffffff; in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("hold_res_data", res_data, FIPS_CT);
      chk1("hold_res_valid", res_valid, 1'b1);
      chk1("hold_in_ready", in_ready, 1'b0);
      chk1("hold_busy", busy, 1'b1);
    end
    in_valid = 1'b0;
    chki("no_second_load", n_load, n0);
    chk("pt_held", plain_text, FIPS_PT);
    drain();

`ifdef AES_KEY_REUSE_EN
    // Key stays full: fifth key word refused, second block needs plaintext only
    offer_reject(32'h5555aaaa, FIPS_KEY);
    q_key.push_back(FIPS_KEY); q_pt.push_back(P2); q_res.push_back(core_f(FIPS_KEY, P2));
    send_block(1'b0, P2);
    wait_res("reuse_block");
    drain();
`else
    // Plaintext full, key partial: launch only on the fourth key word
    q_key.push_back(K2); q_pt.push_back(P2); q_res.push_back(core_f(K2, P2));
    send_block(1'b0, P2);
    for (int i = 0; i < 3; i++) send(1'b1, K2[127-32*i -: 32]);
    n0 = n_load;
    repeat (20) @(negedge clk);
    chki("no_load_partial_key", n_load, n0);
    chk1("idle_partial_key", busy, 1'b0);
    send(1'b1, K2[31:0]);
    wait_res("rekey_block");
    drain();
    send_block(1'b1, K3);
    offer_reject(32'h5555aaaa, K3);
`endif

    // Reset in the middle of RUN
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    q_key.push_back(K2); q_pt.push_back(P2);
    send_block(1'b1, K2);
    send_block(1'b0, P2);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (load_plain_text) seen = 1'b1;
      end
      chk1("midrun_load_seen", seen, 1'b1);
    end
    repeat (7) @(posedge clk);
    #1;
    chki("lat_cnt_before_rst", int'(dut.lat_cnt), 5);
    n0 = n_rv;
    rst = 1'b1;
    #1;
    chk1("midrst_in_ready", in_ready, 1'b0);
    chk1("midrst_load", load_plain_text, 1'b0);
    chk1("midrst_res_valid", res_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk("midrst_key", key, '0);
    chk("midrst_pt", plain_text, '0);
    chk("midrst_res_data", res_data, '0);
    chk1("midrst_state_collect", dut.state == ST_COLLECT, 1'b1);
    @(posedge clk); #1; rst = 1'b0;
    in_sel = 1'b0;
    repeat (30) @(negedge clk);
    chki("midrst_no_result", n_rv, n0);
    chk1("midrst_idle", busy, 1'b0);
    chk1("midrst_in_ready_back", in_ready, 1'b1);

    // Interleaved key/plaintext words
    n0 = n_load;
    q_key.push_back(K5); q_pt.push_back(P5); q_res.push_back(core_f(K5, P5));
    for (int i = 0; i < 4; i++) begin
      send(1'b1, K5[127-32*i -: 32]);
      send(1'b0, P5[127-32*i -: 32]);
    end
    wait_res("interleave");
    drain();
    chki("single_launch", n_load, n0 + 1);

    repeat (5) @(negedge clk);
    chki("pending_loads", q_key.size(), 0);
    chki("pending_results", q_res.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
